// File: rtl/wr_fifo.sv
// Store buffer between write-back and the dcache, drained oldest-first, with load/store overlap detection.
// Optional sticky overflow flag is built when WR_FIFO_OVF_CHK_EN is defined.

module wr_fifo_ovlp (
    input  logic [31:0] a_addr,
    input  logic [1:0]  a_size,
    input  logic [31:0] b_addr,
    input  logic [1:0]  b_size,
    output logic        hit
);
    logic [32:0] a_start, a_end, b_start, b_end;

    // 33-bit ranges so an access touching 0xFFFFFFFF never wraps to address 0
    always_comb begin
        a_start = {1'b0, a_addr};
        b_start = {1'b0, b_addr};
        a_end   = a_start + (33'd1 << a_size) - 33'd1;
        b_end   = b_start + (33'd1 << b_size) - 33'd1;
        hit     = (a_start <= b_end) && (b_start <= a_end);
    end
endmodule

module wr_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_st_valid,
    input  logic [31:0] wb_st_addr,
    input  logic [63:0] wb_st_data,
    input  logic [1:0]  wb_st_size,
    input  logic        mem_wr_done,
    input  logic [31:0] ld_addr,
    input  logic [1:0]  ld_size,
    input  logic        ld_valid,
    output logic [31:0] mem_wr_addr,
    output logic [63:0] mem_wr_data,
    output logic [1:0]  mem_wr_size,
    output logic        wr_fifo_empty,
    output logic        wr_fifo_to_be_full,
    output logic        wr_fifo_full,
    output logic        mem_conflict,
    output logic        wr_fifo_ovf
);
    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } st_entry_t;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TBF_CNT  = (PTR_W+1)'(DEPTH - 1);

    st_entry_t        ent [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PTR_W-1:0] wp, rp;
    logic [PTR_W:0]   cnt;
    logic             push, pop;

    assign wr_fifo_empty      = (cnt == '0);
    assign wr_fifo_full       = (cnt == FULL_CNT);
    assign wr_fifo_to_be_full = (cnt >= TBF_CNT);

    // A pop only happens with a valid head, so a push into an empty FIFO is never drained in the same cycle
    assign pop  = mem_wr_done && !wr_fifo_empty;
    assign push = wb_st_valid && (!wr_fifo_full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            vld <= '0;
        end else begin
            // clear before set: when full, the freed slot is the one being refilled
            if (pop) begin
                vld[rp] <= 1'b0;
                rp      <= rp + 1'b1;
            end
            if (push) begin
                vld[wp] <= 1'b1;
                wp      <= wp + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            ent[wp] <= '{addr: wb_st_addr, data: wb_st_data, size: wb_st_size};
    end

    assign mem_wr_addr = ent[rp].addr;
    assign mem_wr_data = ent[rp].data;
    assign mem_wr_size = ent[rp].size;

    logic [DEPTH-1:0] ent_hit;
    logic             in_hit;

    for (genvar i = 0; i < DEPTH; i++) begin : g_ovlp
        wr_fifo_ovlp u_ovlp (
            .a_addr (ent[i].addr),
            .a_size (ent[i].size),
            .b_addr (ld_addr),
            .b_size (ld_size),
            .hit    (ent_hit[i])
        );
    end

    wr_fifo_ovlp u_ovlp_in (
        .a_addr (wb_st_addr),
        .a_size (wb_st_size),
        .b_addr (ld_addr),
        .b_size (ld_size),
        .hit    (in_hit)
    );

    assign mem_conflict = ld_valid && ((|(ent_hit & vld)) || (wb_st_valid && in_hit));

`ifdef WR_FIFO_OVF_CHK_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (wb_st_valid && wr_fifo_full && !mem_wr_done) begin
            ovf_q <= 1'b1;
`ifndef SYNTHESIS
            $display("wr_fifo: overflow, dropped store addr 0x%08h", wb_st_addr);
`endif
        end
    end

    assign wr_fifo_ovf = ovf_q;
`else
    assign wr_fifo_ovf = 1'b0;
`endif
endmodule

// File: doc/wr_fifo.md
Name: wr_fifo

Overview:
- Store buffer between the write-back stage and the data cache.
- Write-back pushes committed stores (address, data, size). The dcache drains them oldest-first, popping one entry per `mem_wr_done`.
- Also detects overlap between a pending load and any buffered or incoming store, and drives `mem_conflict` so the arbiter orders the load after the store.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PTR_W, 2, log2(DEPTH); read/write pointer width.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- wb_st_valid  input  1  push request from write-back.
- wb_st_addr  input  32  store virtual address.
- wb_st_data  input  64  store data, right-aligned.
- wb_st_size  input  2  store size: 0=1B, 1=2B, 2=4B, 3=8B.
- mem_wr_done  input  1  dcache completed the head entry; pop.
- ld_addr  input  32  pending load address from read-operand.
- ld_size  input  2  pending load size (same encoding).
- ld_valid  input  1  load address valid.
- mem_wr_addr  output  32  head entry address.
- mem_wr_data  output  64  head entry data.
- mem_wr_size  output  2  head entry size.
- wr_fifo_empty  output  1  no valid entries.
- wr_fifo_to_be_full  output  1  count >= DEPTH-1; write-back must stall.
- wr_fifo_full  output  1  count == DEPTH.
- mem_conflict  output  1  load overlaps a buffered or incoming store.
- wr_fifo_ovf  output  1  sticky overflow error (see Optional Feature).

Behaviour:
- Storage:
  - DEPTH entries of {addr[31:0], data[63:0], size[1:0]} plus a per-entry valid bit.
  - Write pointer `wp` and read pointer `rp`, each PTR_W bits, wrapping modulo DEPTH.
  - Count is PTR_W+1 bits.
- Reset (async, `rst` high), held until the first clk edge after deassertion:
  - `wp`, `rp` and count are 0; all valid bits are 0.
  - `wr_fifo_empty`=1; `wr_fifo_to_be_full`=0; `wr_fifo_full`=0; `mem_conflict`=0; `wr_fifo_ovf`=0.
  - `mem_wr_addr`/`data`/`size` read entry 0; their contents are don't-care while empty.
  - Reset mid-operation discards all entries with no pop.
- Push:
  - Accepted on a clk edge when `wb_st_valid` && (!full || pop this cycle).
  - Writes entry[`wp`], sets its valid bit, increments `wp`.
- Pop:
  - Occurs on a clk edge when `mem_wr_done` && !empty.
  - Clears valid[`rp`] and increments `rp`.
  - `mem_wr_done` while empty is ignored.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - When full, the freed slot is reused in the same cycle.
  - When empty, the pushed entry is NOT popped; it becomes the head the next cycle.
- Push while full without a pop: the push is dropped and the state is unchanged. `wr_fifo_ovf` behaviour is under Optional Feature.
- Head outputs:
  - Combinational from entry[`rp`]. Zero-cycle latency after a pop: the next entry is visible right after the edge.
  - A store pushed into an empty FIFO appears on the head outputs one cycle after the push edge.
- Flags: registered-state combinational.
  - `wr_fifo_empty` = (count==0).
  - `wr_fifo_full` = (count==DEPTH).
  - `wr_fifo_to_be_full` = (count>=DEPTH-1).
- Conflict (combinational):
  - Byte length = 1<<size.
  - Ranges are computed as 33-bit [start, start+len-1], so no wrap at 0xFFFFFFFF.
  - Two ranges overlap when a_start <= b_end && b_start <= a_end.
  - `mem_conflict` = `ld_valid` && (any valid entry overlaps the load range || (`wb_st_valid` && the incoming store overlaps the load range)).
  - An entry being popped on the current edge still counts as valid until that edge.

Optional Feature:
- Macro: `WR_FIFO_OVF_CHK_EN`.
- Defined:
  - `wr_fifo_ovf` is set on any clk edge where `wb_st_valid` && full && !`mem_wr_done`.
  - Once set, it stays 1 until `rst`.
  - A simulation-only `$display` prints the dropped address.
- Undefined:
  - `wr_fifo_ovf` is tied to 0.
  - No overflow logic is generated; a dropped push stays silent.

Test Plan:
- Reset, then push addr 0x1000 data 0x1122334455667788 size 3 -> next cycle `wr_fifo_empty`=0, `mem_wr_addr`=0x1000, `mem_wr_data`=0x1122334455667788, `mem_wr_size`=3.
- Push 4 stores (0x100, 0x110, 0x120, 0x130) with no pop:
  - `to_be_full`=1 after the 3rd push; `full`=1 after the 4th.
  - Then pop 4 times -> head outputs 0x100, 0x110, 0x120, 0x130 in order; `empty`=1 after the last pop.
- Full FIFO, push 0x200 with `mem_wr_done` in the same cycle -> count stays 4. The 0x200 entry appears at head after 3 further pops, i.e. pointer wrap is verified.
- Entry addr 0x1006 size 1 (bytes 0x1006-0x1007):
  - Load 0x1004 size 2 (0x1004-0x1007) -> `mem_conflict`=1.
  - Load 0x1008 size 3 -> `mem_conflict`=0.
  - Load 0x1007 size 0 with `ld_valid`=0 -> 0.
- Empty FIFO, `mem_wr_done`=1 with push 0x300 in the same cycle -> count=1 and head=0x300 next cycle. Separately, entry 0xFFFFFFFC size 3 against load 0x0 size 0 -> `mem_conflict`=0 (no wrap).
- With `WR_FIFO_OVF_CHK_EN`:
  - Full FIFO, push without pop -> `wr_fifo_ovf`=1 next cycle; it remains 1 after 4 pops; `rst` clears it.
  - Without the macro -> `wr_fifo_ovf`=0 always, and contents are unchanged by the dropped push.
